phase_timer_bank: RTL and testbench
===================================

# phase_timer_bank

Bank of independent saturating down-timers, one per traffic-light phase channel, that generalises the single-channel saturation counter. Width and channel count are parameters. Each channel adds a per-channel reload mode (one-shot or auto-reload), a saturating extend operation for pedestrian/vehicle extensions, and a registered one-cycle expiry pulse. The block sits between the phase controller FSM and the light decoders: the controller issues load/extend/down commands, and the expiry pulses drive phase advance.

## Interface
Parameters:
- `WIDTH`, 6, count width per channel (≥2)
- `CHANNELS`, 4, number of independent timers (≥1)

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; asserting low clears all state immediately.
- `load`  in  CHANNELS  per-channel load strobe.
- `extend`  in  CHANNELS  per-channel extend strobe.
- `down`  in  CHANNELS  per-channel count-down enable.
- `mode`  in  CHANNELS  0 = one-shot, 1 = auto-reload; sampled only on load.
- `load_val`  in  CHANNELS*WIDTH  flattened; channel i uses bits [i*WIDTH +: WIDTH].
- `ext_val`  in  CHANNELS*WIDTH  flattened extend amount, same slicing.
- `curr_count`  out  CHANNELS*WIDTH  flattened registered counts.
- `is_zero`  out  CHANNELS  combinational (curr_count slice == 0).
- `expire`  out  CHANNELS  registered one-cycle pulse.

## Operation
Each channel holds three registers: `count` (WIDTH bits), `reload` (WIDTH bits) and `mode_q` (1 bit).

Per-channel command priority: reset > load > extend > down > hold.
- load: `count` ← load_val, `reload` ← load_val, `mode_q` ← mode.
- extend (load low): `count` ← min(count + ext_val, 2^WIDTH−1).
  - Compute the sum at WIDTH+1 bits; if the carry is set, saturate to all-ones.
  - extend applies even when `count` is 0.
- down (load and extend low):
  - count > 0: `count` ← count − 1.
  - count == 0, mode_q = 1: `count` ← reload.
  - count == 0, mode_q = 0: hold at 0. Never wraps to all-ones.
- No strobe: hold.

expire:
- `expire` ← 1 on the clock edge where a down decrement takes `count` from 1 to 0.
- Otherwise `expire` ← 0.
- Loading 0, or an auto-reload from 0, does not produce an expire pulse.
- With auto-reload and reload = N ≥ 1 under continuous down, the channel expires once every N+1 cycles.

Channels are fully independent; simultaneous strobes on different channels are all honoured in the same cycle.

## Timing
- Reset (reset low, asynchronous): `count` = 0, `reload` = 0, `mode_q` = 0, `expire` = 0 on all channels. Consequently `is_zero` = all ones.
- Deassertion of reset is synchronised externally; the block needs no internal synchroniser.
- Every command takes effect at the next rising clk edge; `curr_count` reflects it one cycle after the strobe is sampled.
- `expire` rises in the same cycle `curr_count` first reads 0 and is high for exactly one cycle.
- `is_zero` has zero latency relative to `curr_count`.
- Reset mid-countdown aborts the countdown. Any pending expire is lost, and `expire` drops asynchronously.
- load and down asserted together: load wins, with no decrement.
- load with load_val = 0: count = 0, is_zero = 1, expire = 0.

## Structure
Shared package (`timer_pkg`):
- `MODE_ONESHOT` = 0 and `MODE_RELOAD` = 1 constants.
- Command-select encoding used for the per-channel next-state mux (RESET, LOAD, EXTEND, DOWN, HOLD).

Sub-module `timer_channel`:
- Parameter: WIDTH.
- Contains one channel's registers, the saturating add/decrement datapath, the priority select logic and the expire flop.

Top level:
- A generate loop instantiating CHANNELS copies.
- Slicing of the flattened buses.
- No cross-channel logic.

## Test plan
1. Reset behaviour: hold reset low mid-count (count 9) → curr_count = 0, is_zero = 1, expire = 0 immediately, without waiting for a clock edge.
2. One-shot countdown: load 3 with mode 0, then down continuously → counts 3, 2, 1, 0, 0, …; expire high exactly once, in the cycle count reads 0.
3. Auto-reload: load 2 with mode 1, continuous down → 2, 1, 0, 2, 1, 0, …; expire pulses every 3rd cycle.
4. Extend saturation (WIDTH = 6): count 60, extend with ext_val 10 → count 63, no wrap. Count 0, extend 5 → count 5.
5. Priority: load 7 together with down and extend in the same cycle → count 7. Extend 4 together with down from count 5 → count 9.
6. Channel independence (CHANNELS = 4):
   - Stimulus: ch0 load 1, ch1 extend, ch2 down from 0 in one-shot mode, ch3 idle, all in the same cycle.
   - Required response: every channel updates exactly as if it were driven alone; ch2 stays at 0 with no expire.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and the command-select encoding for the phase timer bank.
package timer_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic [2:0] {
    CMD_RESET,
    CMD_LOAD,
    CMD_EXTEND,
    CMD_DOWN,
    CMD_HOLD
  } cmd_e;

  // Reset is asynchronous, so the synchronous select only ever resolves LOAD..HOLD.
  function automatic cmd_e cmd_sel(input logic load, input logic extend, input logic down);
    if (load)        cmd_sel = CMD_LOAD;
    else if (extend) cmd_sel = CMD_EXTEND;
    else if (down)   cmd_sel = CMD_DOWN;
    else             cmd_sel = CMD_HOLD;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One saturating down-timer: count/reload/mode registers, saturating extend,
// optional auto-reload and a registered expiry pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             extend,
  input  logic             down,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] ext_val,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  logic [WIDTH-1:0] reload, count_d, reload_d;
  logic             mode_q, mode_d, expire_d;
  logic [WIDTH:0]   sum;
  cmd_e             cmd;

  always_comb begin
    cmd      = cmd_sel(load, extend, down);
    sum      = {1'b0, count} + {1'b0, ext_val};
    count_d  = count;
    reload_d = reload;
    mode_d   = mode_q;
    expire_d = 1'b0;
    case (cmd)
      CMD_LOAD: begin
        count_d  = load_val;
        reload_d = load_val;
        mode_d   = mode;
      end
      CMD_EXTEND: count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      CMD_DOWN: begin
        if (count != '0) begin
          count_d  = count - WIDTH'(1);
          expire_d = (count == WIDTH'(1));
        end else if (mode_q == MODE_RELOAD) begin
          // reload from zero is silent; only the 1->0 step pulses expire
          count_d = reload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      reload <= '0;
      mode_q <= MODE_ONESHOT;
      expire <= 1'b0;
    end else begin
      count  <= count_d;
      reload <= reload_d;
      mode_q <= mode_d;
      expire <= expire_d;
    end
  end

endmodule

// File: rtl/phase_timer_bank.sv
// Bank of CHANNELS independent phase timers; slices the flattened buses per channel.
module phase_timer_bank
  import timer_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       extend,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS*WIDTH-1:0] ext_val,
  output logic [CHANNELS*WIDTH-1:0] curr_count,
  output logic [CHANNELS-1:0]       is_zero,
  output logic [CHANNELS-1:0]       expire
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load[i]),
      .extend   (extend[i]),
      .down     (down[i]),
      .mode     (mode[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .ext_val  (ext_val[i*WIDTH +: WIDTH]),
      .count    (curr_count[i*WIDTH +: WIDTH]),
      .expire   (expire[i])
    );
    assign is_zero[i] = (curr_count[i*WIDTH +: WIDTH] == '0);
  end

endmodule

// File: tb/tb_phase_timer_bank.sv
// Directed + randomized bench for phase_timer_bank against a per-channel arithmetic model.
module tb_phase_timer_bank;

  localparam int W   = 6;
  localparam int CH  = 4;
  localparam int MAX = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     load, extend, down, mode;
  logic [CH*W-1:0]   load_val, ext_val, curr_count;
  logic [CH-1:0]     is_zero, expire;

  int total = 0;
  int bad   = 0;
  int m_cnt[CH], m_rel[CH], m_md[CH], m_exp[CH];
  int seen[CH];

  always #5 clk = ~clk;

  phase_timer_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .load(load), .extend(extend), .down(down),
    .mode(mode), .load_val(load_val), .ext_val(ext_val),
    .curr_count(curr_count), .is_zero(is_zero), .expire(expire)
  );

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s cnt%0d", tag, c), int'(curr_count[c*W +: W]), m_cnt[c]);
      chk($sformatf("%s zero%0d", tag, c), int'(is_zero[c]), (m_cnt[c] == 0) ? 1 : 0);
      chk($sformatf("%s exp%0d", tag, c), int'(expire[c]), m_exp[c]);
    end
  endtask

  task automatic idle();
    load = '0; extend = '0; down = '0;
  endtask

  task automatic set_lv(input int c, input int v);
    load_val[c*W +: W] = W'(v);
  endtask

  task automatic set_ev(input int c, input int v);
    ext_val[c*W +: W] = W'(v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_md[c] = 0; m_exp[c] = 0;
    end
  endtask

  // One clock: the model applies the priority rules to the inputs seen at the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      m_exp[c] = 0;
      if (load[c]) begin
        m_cnt[c] = int'(load_val[c*W +: W]);
        m_rel[c] = m_cnt[c];
        m_md[c]  = int'(mode[c]);
      end else if (extend[c]) begin
        m_cnt[c] = m_cnt[c] + int'(ext_val[c*W +: W]);
        if (m_cnt[c] > MAX) m_cnt[c] = MAX;
      end else if (down[c]) begin
        if (m_cnt[c] > 0) begin
          m_exp[c] = (m_cnt[c] == 1) ? 1 : 0;
          m_cnt[c] = m_cnt[c] - 1;
        end else if (m_md[c] == 1) begin
          m_cnt[c] = m_rel[c];
        end
      end
    end
    @(negedge clk);
    check_all(tag);
    for (int c = 0; c < CH; c++) seen[c] += int'(expire[c]);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all(tag);
    chk({tag, " zero_all"}, int'(is_zero), (1 << CH) - 1);
    @(posedge clk);
    @(negedge clk);
    check_all({tag, " held"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    mode = '0; load_val = '0; ext_val = '0;
    model_reset();
    for (int c = 0; c < CH; c++) seen[c] = 0;
    repeat (2) @(negedge clk);
    check_all("por");
    reset = 1'b1;

    // reset mid-countdown at count 9
    set_lv(0, 10); load[0] = 1'b1; tick("ld10");
    idle(); down[0] = 1'b1; tick("dn9");
    chk("at9", int'(curr_count[0 +: W]), 9);
    idle();
    do_reset("rst9");
    chk("rst9 cnt", int'(curr_count[0 +: W]), 0);

    // reset drops an active expire pulse asynchronously
    set_lv(0, 1); load[0] = 1'b1; tick("ld1");
    idle(); down[0] = 1'b1; tick("dn1");
    chk("pulse before rst", int'(expire[0]), 1);
    idle();
    do_reset("rstexp");

    // one-shot countdown from 3
    mode[0] = 1'b0; set_lv(0, 3); load[0] = 1'b1; tick("os_ld");
    idle(); down[0] = 1'b1; seen[0] = 0;
    repeat (6) tick("os_dn");
    chk("oneshot pulses", seen[0], 1);
    chk("oneshot end", int'(curr_count[0 +: W]), 0);

    // auto-reload of 2: expire every 3rd cycle
    idle(); mode[1] = 1'b1; set_lv(1, 2); load[1] = 1'b1; tick("ar_ld");
    idle(); down[1] = 1'b1; seen[1] = 0;
    repeat (9) tick("ar_dn");
    chk("reload pulses", seen[1], 3);

    // saturating extend and extend from zero
    idle(); set_lv(2, 60); load[2] = 1'b1; tick("sat_ld");
    idle(); set_ev(2, 10); extend[2] = 1'b1; tick("sat_ext");
    chk("sat 63", int'(curr_count[2*W +: W]), 63);
    idle(); set_lv(2, 0); load[2] = 1'b1; tick("z_ld");
    idle(); set_ev(2, 5); extend[2] = 1'b1; tick("z_ext");
    chk("ext0 5", int'(curr_count[2*W +: W]), 5);

    // priority: load > extend > down
    idle(); set_lv(3, 7); set_ev(3, 3); load[3] = 1'b1; extend[3] = 1'b1; down[3] = 1'b1;
    tick("pri_ld");
    chk("pri load 7", int'(curr_count[3*W +: W]), 7);
    idle(); set_lv(3, 5); load[3] = 1'b1; tick("pri_ld5");
    idle(); set_ev(3, 4); extend[3] = 1'b1; down[3] = 1'b1; tick("pri_ext");
    chk("pri ext 9", int'(curr_count[3*W +: W]), 9);

    // channel independence
    idle(); mode = '0;
    set_lv(0, 30); set_lv(1, 10); set_lv(2, 0); set_lv(3, 20);
    load = '1; tick("ind_ld");
    idle(); set_lv(0, 1); load[0] = 1'b1; set_ev(1, 3); extend[1] = 1'b1; down[2] = 1'b1;
    tick("ind");
    chk("ind ch0", int'(curr_count[0 +: W]), 1);
    chk("ind ch1", int'(curr_count[W +: W]), 13);
    chk("ind ch2", int'(curr_count[2*W +: W]), 0);
    chk("ind ch2 exp", int'(expire[2]), 0);
    chk("ind ch3", int'(curr_count[3*W +: W]), 20);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      for (int c = 0; c < CH; c++) begin
        load[c]   = ($urandom_range(0, 11) == 0);
        extend[c] = ($urandom_range(0, 7) == 0);
        down[c]   = ($urandom_range(0, 3) != 0);
        mode[c]   = 1'($urandom_range(0, 1));
        set_lv(c, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, MAX));
        set_ev(c, ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX) : $urandom_range(0, 6));
      end
      tick("rnd");
      if (it == 150 || it == 300) begin
        idle();
        do_reset("rnd_rst");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
